// File: rtl/fb_pkg.sv
// Frame-buffer geometry shared by the arbiter, FIFO and writer interface.
// Also holds the helper that maps a 640x480 display coordinate onto the 320x240 buffer.
package fb_pkg;
    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_DEPTH  = 76800;
    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 16;

    // 2x upscale: each buffer word covers a 2x2 block of display pixels.
    function automatic logic [FB_ADDR_W-1:0] fb_rd_addr(input logic [9:0] x, input logic [9:0] y);
        logic [FB_ADDR_W-1:0] xs, ys;
        xs = FB_ADDR_W'(x >> 1);
        ys = FB_ADDR_W'(y >> 1);
        return ys * FB_ADDR_W'(FB_W) + xs;
    endfunction
endpackage

// File: rtl/fb_if.sv
// Writer-side valid/ready handshake into the frame-buffer arbiter.
interface fb_if import fb_pkg::*; #(parameter int DATA_W = FB_DATA_W) ();
    logic                 wr_valid;
    logic                 wr_ready;
    logic [FB_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]    wr_data;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO for pending frame-buffer writes; head entry is visible on dout.
// Callers must not push when full or pop when empty.
module fb_wr_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr[AW-1:0]] <= din;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = store[rd_ptr[AW-1:0]];
endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, queued writes fill idle cycles.
// Read data is captured one clock after the read and presented on pix_data the clock after that.
module fb_arbiter import fb_pkg::*; #(
    parameter int DATA_W     = FB_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pixel_tick,
    input  logic                 display_en,
    input  logic [9:0]           x_coor,
    input  logic [9:0]           y_coor,
    fb_if.slave                  wr,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [DATA_W-1:0]    pix_data,
    output logic                 wr_oob
);
    localparam int ENT_W = FB_ADDR_W + DATA_W;

    logic [ENT_W-1:0]     fifo_dout;
    logic                 fifo_full, fifo_empty;
    logic                 rd_req, push, pop, head_oob;
    logic [FB_ADDR_W-1:0] head_addr, rd_addr;
    logic [DATA_W-1:0]    head_data;
    logic                 tick_q, rd_q;

    // Gating with reset keeps the RAM untouched during the reset cycle.
    assign rd_req      = reset & pixel_tick & display_en;
    assign wr.wr_ready = reset & ~fifo_full;
    assign push        = wr.wr_valid & wr.wr_ready;
    assign pop         = reset & ~rd_req & ~fifo_empty;
    assign {head_addr, head_data} = fifo_dout;
    assign head_oob    = head_addr >= FB_ADDR_W'(FB_DEPTH);
    assign rd_addr     = fb_rd_addr(x_coor, y_coor);

    fb_wr_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({wr.wr_addr, wr.wr_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_req) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
        end else if (pop && !head_oob) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head_addr;
            mem_wdata = head_data;
        end
    end

    // A blanked tick still advances the pipe so pix_data goes black on schedule.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_q   <= 1'b0;
            rd_q     <= 1'b0;
            pix_data <= '0;
            wr_oob   <= 1'b0;
        end else begin
            tick_q <= pixel_tick;
            rd_q   <= rd_req;
            if (tick_q) pix_data <= rd_q ? mem_rdata : '0;
            if (pop && head_oob) wr_oob <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: expected RAM transactions queue up at stimulus time,
// a negedge monitor pops and compares every bus cycle.
module tb_fb_arbiter;
    import fb_pkg::*;
    localparam int DW = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           pixel_tick = 1'b0;
    logic           display_en = 1'b0;
    logic [9:0]     x_coor = '0;
    logic [9:0]     y_coor = '0;
    logic           mem_en, mem_we, wr_oob;
    logic [16:0]    mem_addr;
    logic [DW-1:0]  mem_wdata, pix_data;
    logic [DW-1:0]  mem_rdata = '0;

    fb_if #(.DATA_W(DW)) wr ();

    fb_arbiter #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (pixel_tick),
        .display_en (display_en),
        .x_coor     (x_coor),
        .y_coor     (y_coor),
        .wr         (wr),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pix_data   (pix_data),
        .wr_oob     (wr_oob)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_rd_q [$];
    logic [32:0] exp_wr_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every bus cycle is either an expected read, an expected write, or all-zero idle.
    always @(negedge clk) begin
        if (mem_en && mem_we) begin
            if (exp_wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none", mem_addr, mem_wdata);
            end else begin
                chk("mem_write", 64'({mem_addr, mem_wdata}), 64'(exp_wr_q.pop_front()));
            end
        end else if (mem_en) begin
            if (exp_rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read: got addr %0d expected none", mem_addr);
            end else begin
                chk("mem_read", 64'(mem_addr), 64'(exp_rd_q.pop_front()));
            end
        end else begin
            chk("idle_bus", 64'({mem_we, mem_addr, mem_wdata}), 64'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_acc;
        logic [5:0] rdy_exp;
        wr.wr_valid = 1'b0;
        wr.wr_addr  = '0;
        wr.wr_data  = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_ready", 64'(wr.wr_ready), 64'(0));
        chk("rst_pix", 64'(pix_data), 64'(0));
        chk("rst_oob", 64'(wr_oob), 64'(0));
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        cyc(); reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(wr.wr_ready), 64'(1));

        // read path: (3>>1)*320 + (5>>1) = 322
        cyc(); pixel_tick = 1'b1; display_en = 1'b1; x_coor = 10'd5; y_coor = 10'd3;
        exp_rd_q.push_back(17'd322);
        @(negedge clk); chk("rd_addr_322", 64'(mem_addr), 64'(322));
        cyc(); pixel_tick = 1'b0; mem_rdata = 16'hF800;
        cyc(); mem_rdata = '0;
        @(negedge clk); chk("pix_F800", 64'(pix_data), 64'h F800);

        // last visible pixel: 239*320 + 319 = 76799
        cyc(); pixel_tick = 1'b1; x_coor = 10'd639; y_coor = 10'd479;
        exp_rd_q.push_back(17'd76799);
        @(negedge clk); chk("rd_addr_corner", 64'(mem_addr), 64'(76799));
        cyc(); pixel_tick = 1'b0; mem_rdata = 16'h07E0;
        cyc(); mem_rdata = '0;
        @(negedge clk); chk("pix_07E0", 64'(pix_data), 64'h07E0);

        // blanking
        cyc(); pixel_tick = 1'b1; display_en = 1'b0;
        @(negedge clk); chk("blank_no_read", 64'(mem_en), 64'(0));
        cyc(); pixel_tick = 1'b0; mem_rdata = 16'h1234;
        cyc(); mem_rdata = '0;
        @(negedge clk); chk("blank_pix_zero", 64'(pix_data), 64'(0));

        // contention: read wins, write follows next cycle
        cyc(); pixel_tick = 1'b1; display_en = 1'b1; x_coor = '0; y_coor = '0;
        exp_rd_q.push_back(17'd0);
        wr.wr_valid = 1'b1; wr.wr_addr = 17'd10; wr.wr_data = 16'hABCD;
        @(negedge clk); chk("contend_ready", 64'(wr.wr_ready), 64'(1));
        exp_wr_q.push_back({17'd10, 16'hABCD});
        cyc(); pixel_tick = 1'b0; wr.wr_valid = 1'b0;
        @(negedge clk); chk("contend_write_next", 64'({mem_we, mem_addr}), 64'({1'b1, 17'd10}));

        // full: ticks every clk starve the drain; 4 accepts then ready drops
        n_acc = 0;
        rdy_exp = 6'b001111;
        for (int k = 0; k < 6; k++) begin
            cyc(); pixel_tick = 1'b1; display_en = 1'b1; x_coor = 10'd2; y_coor = 10'd2;
            exp_rd_q.push_back(17'd321);
            wr.wr_valid = 1'b1; wr.wr_addr = 17'(100 + n_acc); wr.wr_data = 16'(16'h1000 + n_acc);
            @(negedge clk);
            chk($sformatf("full_ready_%0d", k), 64'(wr.wr_ready), 64'(rdy_exp[k]));
            if (wr.wr_ready) begin
                exp_wr_q.push_back({wr.wr_addr, wr.wr_data});
                n_acc++;
            end
        end
        for (int k = 0; k < 10; k++) begin
            cyc(); pixel_tick = 1'b0;
            @(negedge clk);
            if (wr.wr_ready) begin
                exp_wr_q.push_back({wr.wr_addr, wr.wr_data});
                n_acc++;
                break;
            end
        end
        cyc(); wr.wr_valid = 1'b0;
        chk("full_accepts", 64'(n_acc), 64'(5));
        repeat (8) cyc();
        chk("full_drained", 64'(exp_wr_q.size()), 64'(0));

        // out-of-range write is dropped and flagged
        cyc(); wr.wr_valid = 1'b1; wr.wr_addr = 17'd76800; wr.wr_data = 16'hDEAD;
        @(negedge clk); chk("oob_ready", 64'(wr.wr_ready), 64'(1));
        cyc(); wr.wr_valid = 1'b0;
        @(negedge clk); chk("oob_no_write", 64'(mem_en), 64'(0));
        cyc();
        @(negedge clk); chk("oob_set", 64'(wr_oob), 64'(1));
        repeat (3) cyc();
        @(negedge clk); chk("oob_held", 64'(wr_oob), 64'(1));
        cyc(); wr.wr_valid = 1'b1; wr.wr_addr = 17'd76799; wr.wr_data = 16'h1111;
        @(negedge clk); chk("inrange_ready", 64'(wr.wr_ready), 64'(1));
        exp_wr_q.push_back({17'd76799, 16'h1111});
        cyc(); wr.wr_valid = 1'b0;
        @(negedge clk);
        chk("inrange_write", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b1, 17'd76799}));
        chk("oob_still_set", 64'(wr_oob), 64'(1));

        // reset mid-run with three writes queued behind forced ticks
        mem_rdata = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            cyc(); pixel_tick = 1'b1; display_en = 1'b1; x_coor = 10'd2; y_coor = 10'd2;
            exp_rd_q.push_back(17'd321);
            wr.wr_valid = 1'b1; wr.wr_addr = 17'(200 + i); wr.wr_data = 16'(16'h2000 + i);
            @(negedge clk); chk($sformatf("mid_ready_%0d", i), 64'(wr.wr_ready), 64'(1));
        end
        cyc(); wr.wr_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_pix_before", 64'(pix_data), 64'h FFFF);
        chk("mid_rst_ready", 64'(wr.wr_ready), 64'(0));
        chk("mid_rst_mem_en", 64'(mem_en), 64'(0));
        cyc(); reset = 1'b1; pixel_tick = 1'b0; display_en = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(wr.wr_ready), 64'(1));
        chk("post_rst_pix", 64'(pix_data), 64'(0));
        chk("post_rst_oob", 64'(wr_oob), 64'(0));
        repeat (8) cyc();
        @(negedge clk);
        chk("post_rst_pix_hold", 64'(pix_data), 64'(0));

        chk("rd_queue_empty", 64'(exp_rd_q.size()), 64'(0));
        chk("wr_queue_empty", 64'(exp_wr_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: pixel word width (RGB565).
REQ-002 Parameter FIFO_DEPTH, default 4: write-FIFO entries, power of two.
REQ-003 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 pixel_tick  input  1  one-clk strobe, once per pixel period (every 4 clk).
REQ-006 display_en  input  1  visible-area flag from VGA timing.
REQ-007 x_coor, y_coor  input  10 each  current VGA pixel coordinates, stable while pixel_tick is high.
REQ-008 wr_valid, wr_ready  input/output  1 each  writer handshake; a transfer occurs when both are high on a rising edge.
REQ-009 wr_addr  input  17  frame-buffer word address.
REQ-010 wr_data  input  DATA_W  pixel to write.
REQ-011 mem_en, mem_we  output  1 each  single-port RAM enable and write strobe.
REQ-012 mem_addr  output  17  RAM address.
REQ-013 mem_wdata  output  DATA_W  RAM write data.
REQ-014 mem_rdata  input  DATA_W  RAM read data, valid 1 clk after a read.
REQ-015 pix_data  output  DATA_W  registered pixel to the DAC.
REQ-016 wr_oob  output  1  sticky out-of-range-write flag.

Function
REQ-017 Frame buffer is 320x240 (76800 words), displayed 2x upscaled on 640x480.
REQ-018 Display read address SHALL be (y_coor>>1)*320 + (x_coor>>1), computed at 17-bit width without truncation.
REQ-019 Cycle T with pixel_tick=1 and display_en=1 SHALL issue a read: mem_en=1, mem_we=0, mem_addr set to the display read address.
REQ-020 mem_rdata from a read issued at T SHALL be loaded into pix_data at the rising edge ending T+1, so pix_data is valid during T+2.
REQ-021 A pixel_tick with display_en=0 SHALL issue no read and SHALL load pix_data=0 at the same point, so pix_data=0 during T+2.
REQ-022 Display reads SHALL have absolute priority; the writer SHALL never delay or displace a display read.
REQ-023 Accepted writes SHALL enter a FIFO_DEPTH-entry FIFO; wr_ready SHALL be 1 exactly when the FIFO is not full and reset is deasserted.
REQ-024 In every cycle with no display read and a non-empty FIFO, the head entry SHALL be popped and written: mem_en=1, mem_we=1, addr and data from the entry.
REQ-025 Pushing and popping in the same cycle SHALL leave the occupancy unchanged and preserve order; pushing when full is impossible because wr_ready=0.
REQ-026 A popped entry with address >=76800 SHALL be discarded without a RAM write and SHALL set wr_oob, which stays 1 until reset.
REQ-027 In an idle cycle (no read, FIFO empty), mem_en, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-028 Write order to RAM SHALL equal acceptance order; sustained drain rate is at least 3 writes per 4 clk.

Reset
REQ-029 While reset=0 at a rising edge: FIFO empty, pix_data=0, wr_oob=0, all mem_* outputs 0, wr_ready=0.
REQ-030 Asserting reset mid-transfer SHALL discard FIFO contents and any in-flight read capture; no RAM write occurs in the reset cycle.

Structure
REQ-031 Package fb_pkg SHALL hold FB_W=320, FB_H=240, FB_DEPTH=76800, FB_ADDR_W=17 and the DATA_W default.
REQ-032 Sub-module fb_wr_fifo SHALL implement the synchronous FIFO (push/pop/full/empty, registered storage); the arbiter and read-capture pipeline stay in fb_arbiter.

Verification
REQ-033 Read path: pixel_tick with x=5, y=3, display_en=1 -> mem_addr=322 at T; with mem_rdata=0xF800 at T+1 -> pix_data=0xF800 at T+2.
REQ-034 Blanking: pixel_tick with display_en=0 -> no mem_en that cycle, pix_data=0 two clk later.
REQ-035 Contention: write to addr 10 in the same cycle as pixel_tick/display_en -> read at that cycle, write to addr 10 the next cycle.
REQ-036 Full: 5 writes back-to-back while a pixel_tick fires every clk (forced) -> wr_ready=0 after 4 accepts; the FIFO drains in order after ticks stop.
REQ-037 OOB: write addr 76800 -> no mem_we, wr_oob=1 and held; a later write to 76799 -> normal mem_we.
REQ-038 Reset mid-run: 3 entries queued, reset=0 for 1 clk -> FIFO empty, wr_ready=0 during reset, no subsequent writes of the stale entries.
